vga_capture: RTL

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// Downscaling VGA frame grabber: writes every TIMES-th pixel of one frame into a frame buffer.
// Define CAPTURE_LOCK_CHK_EN to build the line/frame length checker that drives locked.
module vga_capture #(
    parameter int TIMES       = 4,
    parameter int HMAX        = 1040,
    parameter int VMAX        = 666,
    parameter int LEFT_BOUND  = 184,
    parameter int RIGHT_BOUND = 983,
    parameter int UP_BOUND    = 29,
    parameter int DOWN_BOUND  = 628
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [11:0] rgb,
    input  logic        capture_en,
    output logic        we,
    output logic [14:0] waddr,
    output logic [11:0] wdata,
    output logic        busy,
    output logic        frame_done,
    output logic        locked
);

    localparam int HW   = $clog2(HMAX);
    localparam int VW   = $clog2(VMAX);
    localparam int TW   = (TIMES > 1) ? $clog2(TIMES) : 1;
    localparam int COLS = (RIGHT_BOUND - LEFT_BOUND + 1) / TIMES;
    localparam int ROWS = (DOWN_BOUND - UP_BOUND + 1) / TIMES;
    localparam logic [14:0] LAST_ADDR = 15'(COLS * ROWS - 1);
    localparam logic [14:0] ROW_STEP  = 15'(COLS);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, CAPTURE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            hs_q, vs_q, hs_p_q, vs_line_q, vs_line_d;
    logic [11:0]     rgb_q;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [TW-1:0]   hmod_q, hmod_d, vmod_q, vmod_d;
    logic [14:0]     hcol_q, hcol_d, row_q, row_d;
    logic            we_q, we_d, busy_q, busy_d, done_q, done_d, locked_q, locked_d;
    logic [14:0]     waddr_q, waddr_d;
    logic [11:0]     wdata_q, wdata_d;
    logic            line_start_s, frame_start_s, visible_s, sample_s;

    // The _d counters are the current-cycle position; the _q copies hold last cycle's value.
    always_comb begin
        line_start_s  = hs_q & ~hs_p_q;
        frame_start_s = line_start_s & vs_q & ~vs_line_q;
        vs_line_d     = line_start_s ? vs_q : vs_line_q;

        if (line_start_s) begin
            hcnt_d = HW'(0);
        end else if (hcnt_q != HW'(HMAX - 1)) begin
            hcnt_d = hcnt_q + HW'(1);
        end else begin
            hcnt_d = hcnt_q;
        end

        if (frame_start_s) begin
            vcnt_d = VW'(0);
        end else if (line_start_s && (vcnt_q != VW'(VMAX - 1))) begin
            vcnt_d = vcnt_q + VW'(1);
        end else begin
            vcnt_d = vcnt_q;
        end

        if (hcnt_d == HW'(LEFT_BOUND)) begin
            hmod_d = TW'(0);
            hcol_d = 15'd0;
        end else if (hmod_q == TW'(TIMES - 1)) begin
            hmod_d = TW'(0);
            hcol_d = hcol_q + 15'd1;
        end else begin
            hmod_d = hmod_q + TW'(1);
            hcol_d = hcol_q;
        end

        // Row base address advances by one buffer row every TIMES screen lines.
        if (!line_start_s) begin
            vmod_d = vmod_q;
            row_d  = row_q;
        end else if (vcnt_d == VW'(UP_BOUND)) begin
            vmod_d = TW'(0);
            row_d  = 15'd0;
        end else if (vmod_q == TW'(TIMES - 1)) begin
            vmod_d = TW'(0);
            row_d  = row_q + ROW_STEP;
        end else begin
            vmod_d = vmod_q + TW'(1);
            row_d  = row_q;
        end

        visible_s = (hcnt_d >= HW'(LEFT_BOUND)) && (hcnt_d <= HW'(RIGHT_BOUND)) &&
                    (vcnt_d >= VW'(UP_BOUND))   && (vcnt_d <= VW'(DOWN_BOUND));
        sample_s  = visible_s && (hmod_d == TW'(0)) && (vmod_d == TW'(0));
    end

`ifdef CAPTURE_LOCK_CHK_EN
    localparam int LW = $clog2(HMAX + 1);
    localparam int FW = $clog2(VMAX + 1);
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    good_q, good_d;
    logic          hseen_q, hseen_d, vseen_q, vseen_d, dirty_q, dirty_d;
    logic          line_bad_s, frame_bad_s;

    // Measure every line and frame; two clean frames in a row declare the timing stable.
    always_comb begin
        if (line_start_s) begin
            lcnt_d = LW'(0);
        end else if (lcnt_q != LW'(HMAX)) begin
            lcnt_d = lcnt_q + LW'(1);
        end else begin
            lcnt_d = lcnt_q;
        end
        if (frame_start_s) begin
            fcnt_d = FW'(0);
        end else if (line_start_s && (fcnt_q != FW'(VMAX))) begin
            fcnt_d = fcnt_q + FW'(1);
        end else begin
            fcnt_d = fcnt_q;
        end
        line_bad_s  = line_start_s && hseen_q && (lcnt_q != LW'(HMAX - 1));
        frame_bad_s = frame_start_s && vseen_q && (fcnt_q != FW'(VMAX - 1));
        hseen_d     = hseen_q | line_start_s;
        vseen_d     = vseen_q | frame_start_s;
        dirty_d     = frame_start_s ? 1'b0 : (dirty_q | line_bad_s);
        if (line_bad_s || frame_bad_s || (frame_start_s && dirty_q)) begin
            good_d = 2'd0;
        end else if (frame_start_s && vseen_q && (good_q != 2'd2)) begin
            good_d = good_q + 2'd1;
        end else begin
            good_d = good_q;
        end
        locked_d = (good_d == 2'd2);
    end

    // Lock checker state.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            lcnt_q  <= LW'(0);
            fcnt_q  <= FW'(0);
            good_q  <= 2'd0;
            hseen_q <= 1'b0;
            vseen_q <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            lcnt_q  <= lcnt_d;
            fcnt_q  <= fcnt_d;
            good_q  <= good_d;
            hseen_q <= hseen_d;
            vseen_q <= vseen_d;
            dirty_q <= dirty_d;
        end
    end
`else
    assign locked_d = 1'b1;
`endif

    // Capture FSM and registered frame-buffer write port.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_en && locked_q) state_d = WAIT_VS;
                else                        state_d = IDLE;
            end
            WAIT_VS: begin
                if (!locked_q)          state_d = IDLE;
                else if (frame_start_s) state_d = CAPTURE;
                else                    state_d = WAIT_VS;
            end
            CAPTURE: begin
                if (!locked_q || frame_start_s) begin
                    state_d = IDLE;
                end else if (we_q && (waddr_q == LAST_ADDR)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            default: state_d = IDLE;
        endcase
        we_d    = sample_s && (state_q == CAPTURE);
        waddr_d = we_d ? (row_d + hcol_d) : waddr_q;
        wdata_d = we_d ? rgb_q : wdata_q;
        busy_d  = (state_d != IDLE);
    end

    // Input sync, counters, FSM and output registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            rgb_q     <= 12'd0;
            hs_p_q    <= 1'b0;
            vs_line_q <= 1'b0;
            hcnt_q    <= HW'(0);
            vcnt_q    <= VW'(0);
            hmod_q    <= TW'(0);
            vmod_q    <= TW'(0);
            hcol_q    <= 15'd0;
            row_q     <= 15'd0;
            we_q      <= 1'b0;
            waddr_q   <= 15'd0;
            wdata_q   <= 12'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_q      <= hs;
            vs_q      <= vs;
            rgb_q     <= rgb;
            hs_p_q    <= hs_q;
            vs_line_q <= vs_line_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hmod_q    <= hmod_d;
            vmod_q    <= vmod_d;
            hcol_q    <= hcol_d;
            row_q     <= row_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            locked_q  <= locked_d;
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign locked     = locked_q;

endmodule
